// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the fetch-PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC_SEQ     = 2'd0,
        SRC_ID      = 2'd1,
        SRC_EX_BR   = 2'd2,
        SRC_EX_JALR = 2'd3
    } src_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] JALR_MASK   = 32'hFFFF_FFFE;

    function automatic logic is_ex_src(input src_e s);
        return (s == SRC_EX_BR) || (s == SRC_EX_JALR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_target_sel.sv
// ============================================================================
// Module      : pc_target_sel
// Description : Priority arbiter (EX > ID > sequential) feeding one shared
//               PC+X adder; JALR targets get bit 0 cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_sel
    import pc_seq_pkg::*;
(
    input  logic        id_en,
    input  logic [31:0] pc,
    input  logic        ex_br_taken,
    input  logic        ex_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_imm,
    input  logic        id_jal,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    output logic [31:0] target,
    output src_e        source,
    output logic        valid
);

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_sum;

    always_comb begin
        w_op_a = pc;
        w_op_b = INSTR_BYTES;
        source = SRC_SEQ;
        valid  = 1'b0;
        if (ex_jalr) begin
            w_op_a = ex_rs1;
            w_op_b = ex_imm;
            source = SRC_EX_JALR;
            valid  = 1'b1;
        end else if (ex_br_taken) begin
            w_op_a = ex_pc;
            w_op_b = ex_imm;
            source = SRC_EX_BR;
            valid  = 1'b1;
        end else if (id_jal && id_en) begin
            w_op_a = id_pc;
            w_op_b = id_imm;
            source = SRC_ID;
            valid  = 1'b1;
        end
    end

    assign w_sum  = w_op_a + w_op_b;
    assign target = (source == SRC_EX_JALR) ? (w_sum & JALR_MASK) : w_sum;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-PC controller with stall-tolerant one-deep redirect
//               pending register, flush generation and redirect counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_br_taken,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_imm,
    input  logic             id_jal,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    output logic [31:0]      pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    src_e             pend_src_q, pend_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;

    logic [31:0]      w_target;
    src_e             w_source;
    logic             w_valid;
    logic             w_flush_if;
    logic             w_flush_id;

    // ID requests seen while a redirect is pending are wrong-path
    pc_target_sel u_target_sel (
        .id_en       (state_q == RUN),
        .pc          (pc_q),
        .ex_br_taken (ex_br_taken),
        .ex_jalr     (ex_jalr),
        .ex_pc       (ex_pc),
        .ex_rs1      (ex_rs1),
        .ex_imm      (ex_imm),
        .id_jal      (id_jal),
        .id_pc       (id_pc),
        .id_imm      (id_imm),
        .target      (w_target),
        .source      (w_source),
        .valid       (w_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_src_d = pend_src_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        w_flush_if = 1'b0;
        w_flush_id = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_d = w_target;
                    if (w_valid) begin
                        w_flush_if = 1'b1;
                        w_flush_id = is_ex_src(w_source);
                        cnt_d      = cnt_q + CNT_W'(1);
                        misalign_d = (w_target[1:0] != 2'b00);
                    end
                end else if (w_valid) begin
                    pend_tgt_d = w_target;
                    pend_src_d = w_source;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (!stall) begin
                    state_d    = RUN;
                    w_flush_if = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (w_valid) begin
                        pc_d       = w_target;
                        w_flush_id = 1'b1;
                        misalign_d = (w_target[1:0] != 2'b00);
                    end else begin
                        pc_d       = pend_tgt_q;
                        w_flush_id = is_ex_src(pend_src_q);
                        misalign_d = (pend_tgt_q[1:0] != 2'b00);
                    end
                end else if (w_valid) begin
                    pend_tgt_d = w_target;
                    pend_src_d = w_source;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
            pend_src_q <= SRC_SEQ;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_src_q <= pend_src_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign flush_if     = w_flush_if;
    assign flush_id     = w_flush_id;
    assign misalign     = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-PC controller for the five-stage pipeline. Owns the architectural fetch PC and arbitrates next-PC redirects from the EX stage (taken branch, JALR) and the ID stage (JAL) against sequential PC+4. It computes every target with a single shared 32-bit PC+X adder path and issues IF/ID flushes. Redirects that arrive while the hazard unit stalls fetch are held in a pending register until the stall lifts.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- CNT_W, 16, width of redirect performance counter

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hazard-unit fetch stall (hold PC and IF/ID)
- ex_br_taken  in  1  EX branch resolved taken
- ex_jalr  in  1  EX JALR valid
- ex_pc  in  32  PC of the EX instruction (branch base)
- ex_rs1  in  32  JALR base register value
- ex_imm  in  32  sign-extended EX offset
- id_jal  in  1  ID JAL valid
- id_pc  in  32  PC of the ID instruction
- id_imm  in  32  sign-extended JAL offset
- pc  out  32  current fetch PC, registered
- flush_if  out  1  kill IF/ID contents at next edge
- flush_id  out  1  kill ID/EX contents at next edge
- misalign  out  1  registered one-cycle pulse: accepted target had bits[1:0] != 0
- redirect_cnt  out  CNT_W  count of applied redirects, wraps

## Operation
- Source priority: EX (ex_br_taken or ex_jalr) > ID (id_jal) > sequential. ex_br_taken and ex_jalr together: JALR wins.
- Targets: branch = ex_pc + ex_imm; JALR = (ex_rs1 + ex_imm) & ~32'h1; JAL = id_pc + id_imm; sequential = pc + 4. All use modulo-2^32 arithmetic and ignore carry-out.
- A single adder computes the selected operand pair.
- FSM states: RUN and PEND.
- RUN, no request, stall=0: pc <= pc+4.
- RUN, no request, stall=1: pc holds.
- RUN, request, stall=0: pc <= target, redirect_cnt++, stay RUN.
- RUN, request, stall=1: pend_tgt <= target, pend_src <= source, pc holds, go to PEND.
- PEND, stall=1:
  - A new EX request overwrites pend_tgt/pend_src.
  - An ID request is ignored (it is wrong-path).
- PEND, stall=0: pc <= pend_tgt, redirect_cnt++, go to RUN. Same-cycle EX request takes precedence over pend_tgt. Same-cycle ID request is ignored.
- Flushes are combinational from the current state and inputs:
  - flush_if=1 on any accepted request cycle and on the PEND→RUN cycle.
  - flush_id=1 only on cycles accepting an EX-source request.
- misalign: set the cycle after an accepted target has bits[1:0] != 0. The target is still applied unmodified.

## Timing
- Reset (async assert): pc=RESET_PC, state=RUN, pend_tgt=0, flush_if=0, flush_id=0, misalign=0, redirect_cnt=0.
- Reset mid-PEND discards the pending target.
- Redirect latency is one edge: request at cycle n gives pc=target in cycle n+1 when stall=0 at n.
- Under stall, the redirect takes effect one edge after the first cycle with stall=0.
- Wrap-around: pc=32'hFFFF_FFFC sequential → 32'h0000_0000. redirect_cnt wraps from all-ones to 0.
- Redirects never overlap. At most one is applied per edge, and pending depth is 1.

## Structure
- Package pc_seq_pkg holds:
  - state enum {RUN, PEND}
  - source enum {SRC_SEQ, SRC_ID, SRC_EX_BR, SRC_EX_JALR}
  - INSTR_BYTES = 4
  - JALR_MASK = 32'hFFFF_FFFE
- Sub-module pc_target_sel is the combinational priority arbiter plus adder operand mux, with JALR masking. It outputs target, source and valid.
- The top level holds the FSM, pc, pending register, flush logic and counter.

## Test plan
- Reset with RESET_PC=32'h100, no requests for 3 cycles → pc = 0x100, 0x104, 0x108, 0x10C. Flushes stay 0.
- pc=0x200, ex_br_taken with ex_pc=0x1F8, ex_imm=32'hFFFF_FFF0 → flush_if=1 and flush_id=1 that cycle, next pc=0x1E8, redirect_cnt=1.
- Same cycle: ex_jalr (rs1=0x403, imm=0) and id_jal (id_pc=0x300, imm=0x40) → pc=0x402, flush_id=1, JAL dropped.
- stall=1 for 3 cycles, id_jal target 0x500 in cycle 1, ex_br_taken target 0x600 in cycle 2 → pc holds. On the first stall=0 cycle, flush_if=1. Next pc=0x600.
- Reset asserted asynchronously while in PEND (pending 0x700) → pc=RESET_PC immediately. After release, pc goes sequential and 0x700 is never seen.
- ex_br_taken target 0x802 → pc=0x802, misalign pulses 1 for exactly one cycle. Also check sequential pc=0xFFFF_FFFC → 0x0.
